branch_predictor: RTL and testbench

Dynamic branch predictor and redirect controller for the 5-stage RV32I pipeline. In Fetch it looks up a direct-mapped table of 2-bit saturating counters and target addresses and supplies a predicted next PC. It carries each prediction through Decode to Execute, where it compares the prediction against the resolved branch/jump outcome. On a mismatch it raises a mispredict with the corrected PC and updates the table.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 161 ++++++++++++++++
 tb/tb_branch_predictor.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/Execute signal bundle between the RV32I pipeline and branch_predictor.
// The pipeline side uses the master modport; the predictor uses slave.
interface branch_predictor_if;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        BranchE;
    logic        JumpE;
    logic        PCSrcE;
    logic [31:0] PCE;
    logic [31:0] PCTargetE;
    logic [31:0] PCPlus4E;
    logic        PredTakenF;
    logic [31:0] NextPCF;
    logic        MispredictE;
    logic [31:0] RedirectPCE;

    modport master (
        output PCF, PCPlus4F, StallD, FlushD, FlushE, BranchE, JumpE, PCSrcE,
               PCE, PCTargetE, PCPlus4E,
        input  PredTakenF, NextPCF, MispredictE, RedirectPCE
    );

    modport slave (
        input  PCF, PCPlus4F, StallD, FlushD, FlushE, BranchE, JumpE, PCSrcE,
               PCE, PCTargetE, PCPlus4E,
        output PredTakenF, NextPCF, MispredictE, RedirectPCE
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with Execute-stage redirect.
// Define BP_TAG_EN to store per-entry PC tags; otherwise aliasing PCs share entries.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_RESET = 2'b01;

    function automatic ctr_t ctr_sat_inc(input ctr_t c);
        return (c == 2'b11) ? c : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t ctr_sat_dec(input ctr_t c);
        return (c == 2'b00) ? c : ctr_t'(c - 2'd1);
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    ctr_t               ctr_q    [ENTRIES];
    ctr_t               ctr_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [IDX_W-1:0]   idx_f;
    logic [IDX_W-1:0]   idx_e;
    logic               tag_match_f;
    logic               tag_match_e;
    logic               hit_f;
    logic               pred_taken_f;
    logic               ctl_e;
    logic               alloc_e;

    logic               pred_taken_p1_q, pred_taken_p1_d;
    logic [31:0]        pred_target_p1_q, pred_target_p1_d;
    logic               pred_taken_p2_q, pred_taken_p2_d;
    logic [31:0]        pred_target_p2_q, pred_target_p2_d;

    assign idx_f = bp.PCF[IDX_W+1:2];
    assign idx_e = bp.PCE[IDX_W+1:2];

`ifdef BP_TAG_EN
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [TAG_W-1:0] tag_d [ENTRIES];
    logic             unused_pc_bits;

    assign tag_match_f    = (tag_q[idx_f] == bp.PCF[31:IDX_W+2]);
    assign tag_match_e    = (tag_q[idx_e] == bp.PCE[31:IDX_W+2]);
    assign unused_pc_bits = ^{bp.PCF[1:0], bp.PCE[1:0]};
`else
    logic unused_pc_bits;

    assign tag_match_f    = 1'b1;
    assign tag_match_e    = 1'b1;
    assign unused_pc_bits = ^{bp.PCF[31:IDX_W+2], bp.PCF[1:0],
                              bp.PCE[31:IDX_W+2], bp.PCE[1:0]};
`endif

    // Fetch: combinational lookup
    assign hit_f         = valid_q[idx_f] & tag_match_f;
    assign pred_taken_f  = hit_f & ctr_q[idx_f][1];
    assign bp.PredTakenF = pred_taken_f;
    assign bp.NextPCF    = pred_taken_f ? target_q[idx_f] : bp.PCPlus4F;

    // F->D and D->E prediction registers; flush outranks stall
    always_comb begin
        pred_taken_p1_d  = pred_taken_p1_q;
        pred_target_p1_d = pred_target_p1_q;
        if (bp.FlushD) begin
            pred_taken_p1_d  = 1'b0;
            pred_target_p1_d = '0;
        end else if (!bp.StallD) begin
            pred_taken_p1_d  = pred_taken_f;
            pred_target_p1_d = target_q[idx_f];
        end

        pred_taken_p2_d  = bp.FlushE ? 1'b0 : pred_taken_p1_q;
        pred_target_p2_d = bp.FlushE ? '0   : pred_target_p1_q;
    end

    // Execute: resolve against the carried prediction
    assign ctl_e = bp.BranchE | bp.JumpE;

    always_comb begin
        if (ctl_e) begin
            bp.MispredictE = (bp.PCSrcE != pred_taken_p2_q) |
                             (bp.PCSrcE & pred_taken_p2_q & (pred_target_p2_q != bp.PCTargetE));
        end else begin
            bp.MispredictE = pred_taken_p2_q;
        end
        bp.RedirectPCE = (ctl_e & bp.PCSrcE) ? bp.PCTargetE : bp.PCPlus4E;
    end

    assign alloc_e = ~valid_q[idx_e] | ~tag_match_e;

    // Table update from the resolved Execute instruction; jump wins if both flags are set
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        target_d = target_q;
`ifdef BP_TAG_EN
        tag_d    = tag_q;
`endif
        if (bp.JumpE) begin
            valid_d[idx_e]  = 1'b1;
            ctr_d[idx_e]    = 2'b11;
            target_d[idx_e] = bp.PCTargetE;
`ifdef BP_TAG_EN
            tag_d[idx_e]    = bp.PCE[31:IDX_W+2];
`endif
        end else if (bp.BranchE) begin
            valid_d[idx_e] = 1'b1;
            if (alloc_e) begin
                ctr_d[idx_e] = bp.PCSrcE ? 2'b10 : 2'b01;
            end else if (bp.PCSrcE) begin
                ctr_d[idx_e] = ctr_sat_inc(ctr_q[idx_e]);
            end else begin
                ctr_d[idx_e] = ctr_sat_dec(ctr_q[idx_e]);
            end
            if (bp.PCSrcE) begin
                target_d[idx_e] = bp.PCTargetE;
            end
`ifdef BP_TAG_EN
            tag_d[idx_e] = bp.PCE[31:IDX_W+2];
`endif
        end else if (pred_taken_p2_q) begin
            valid_d[idx_e] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
            pred_taken_p1_q <= 1'b0;
            pred_taken_p2_q <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            ctr_q           <= ctr_d;
            pred_taken_p1_q <= pred_taken_p1_d;
            pred_taken_p2_q <= pred_taken_p2_d;
        end
    end

    // Targets and tags are qualified by valid/taken, so they carry no reset
    always_ff @(posedge clk) begin
        target_q         <= target_d;
        pred_target_p1_q <= pred_target_p1_d;
        pred_target_p2_q <= pred_target_p2_d;
`ifdef BP_TAG_EN
        tag_q            <= tag_d;
`endif
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a randomized
// stream checked against a behavioural table model.
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
`ifdef BP_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit          m_valid  [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    bit          m_pd_taken, m_pe_taken;
    logic [31:0] m_pd_tgt, m_pe_tgt;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && (!TAG_EN || m_tag[i] == (pc >> (IDX_W + 2)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_pred(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        if (bp_if.BranchE || bp_if.JumpE)
            return (bp_if.PCSrcE != m_pe_taken) ||
                   (bp_if.PCSrcE && m_pe_taken && m_pe_tgt != bp_if.PCTargetE);
        return m_pe_taken;
    endfunction

    function automatic logic [31:0] m_redir();
        return ((bp_if.BranchE || bp_if.JumpE) && bp_if.PCSrcE) ? bp_if.PCTargetE : bp_if.PCPlus4E;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_pd_taken = 1'b0;
        m_pe_taken = 1'b0;
        m_pd_tgt   = '0;
        m_pe_tgt   = '0;
    endfunction

    function automatic void model_step();
        int          fi, ei;
        bit          f_taken;
        logic [31:0] f_tgt;
        fi      = idx_of(bp_if.PCF);
        f_taken = m_pred(bp_if.PCF);
        f_tgt   = m_target[fi];
        ei      = idx_of(bp_if.PCE);
        if (bp_if.JumpE) begin
            m_valid[ei]  = 1'b1;
            m_ctr[ei]    = 3;
            m_target[ei] = bp_if.PCTargetE;
            m_tag[ei]    = bp_if.PCE >> (IDX_W + 2);
        end else if (bp_if.BranchE) begin
            if (!m_hit(bp_if.PCE))  m_ctr[ei] = bp_if.PCSrcE ? 2 : 1;
            else if (bp_if.PCSrcE)  m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
            else                    m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
            m_valid[ei] = 1'b1;
            m_tag[ei]   = bp_if.PCE >> (IDX_W + 2);
            if (bp_if.PCSrcE) m_target[ei] = bp_if.PCTargetE;
        end else if (m_pe_taken) begin
            m_valid[ei] = 1'b0;
        end
        m_pe_taken = bp_if.FlushE ? 1'b0 : m_pd_taken;
        m_pe_tgt   = bp_if.FlushE ? '0   : m_pd_tgt;
        if (bp_if.FlushD) begin
            m_pd_taken = 1'b0;
            m_pd_tgt   = '0;
        end else if (!bp_if.StallD) begin
            m_pd_taken = f_taken;
            m_pd_tgt   = f_tgt;
        end
    endfunction

    // Called just after a falling edge; leaves outputs settled before the rising edge
    task automatic drive(input logic [31:0] pcf, input bit stall, input bit flushd,
                         input bit flushe, input bit br, input bit jmp, input bit src,
                         input logic [31:0] pce, input logic [31:0] tgt);
        bp_if.PCF       = pcf;
        bp_if.PCPlus4F  = pcf + 32'd4;
        bp_if.StallD    = stall;
        bp_if.FlushD    = flushd;
        bp_if.FlushE    = flushe;
        bp_if.BranchE   = br;
        bp_if.JumpE     = jmp;
        bp_if.PCSrcE    = src;
        bp_if.PCE       = pce;
        bp_if.PCTargetE = tgt;
        bp_if.PCPlus4E  = pce + 32'd4;
        #2;
    endtask

    task automatic idle(input logic [31:0] pcf);
        drive(pcf, 0, 0, 0, 0, 0, 0, 32'h3C, 32'h0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle(32'h20);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        drive(32'h100, 0, 0, 0, 0, 0, 0, 32'h3C, 32'h0);
        n_tests++; if (bp_if.PredTakenF !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %0b want 0", bp_if.PredTakenF); end
        n_tests++; if (bp_if.NextPCF !== 32'h104) begin n_fail++; $display("FAIL reset_nextpc: got %h want 104", bp_if.NextPCF); end
        n_tests++; if (bp_if.MispredictE !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %0b want 0", bp_if.MispredictE); end
        n_tests++; if (bp_if.RedirectPCE !== 32'h40) begin n_fail++; $display("FAIL reset_redirect: got %h want 40", bp_if.RedirectPCE); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h100, 0, 0, 0, 0, 0, 0, 32'h3C, 32'h0);
        n_tests++; if (bp_if.NextPCF !== 32'h104) begin n_fail++; $display("FAIL post_reset_nextpc: got %h want 104", bp_if.NextPCF); end
        tick();
    endtask

    task automatic test_taken_branch();
        do_reset();
        idle(32'h100);
        n_tests++; if (bp_if.PredTakenF !== 1'b0) begin n_fail++; $display("FAIL beq_cold_pred: got %0b want 0", bp_if.PredTakenF); end
        tick();
        idle(32'h104);
        tick();
        drive(32'h108, 0, 1, 1, 1, 0, 1, 32'h100, 32'h80);
        n_tests++; if (bp_if.MispredictE !== 1'b1) begin n_fail++; $display("FAIL beq_first_mis: got %0b want 1", bp_if.MispredictE); end
        n_tests++; if (bp_if.RedirectPCE !== 32'h80) begin n_fail++; $display("FAIL beq_first_redirect: got %h want 80", bp_if.RedirectPCE); end
        tick();
        idle(32'h100);
        n_tests++; if (bp_if.PredTakenF !== 1'b1) begin n_fail++; $display("FAIL beq_trained_pred: got %0b want 1", bp_if.PredTakenF); end
        n_tests++; if (bp_if.NextPCF !== 32'h80) begin n_fail++; $display("FAIL beq_trained_nextpc: got %h want 80", bp_if.NextPCF); end
        tick();
        idle(32'h80);
        tick();
        drive(32'h84, 0, 0, 0, 1, 0, 1, 32'h100, 32'h80);
        n_tests++; if (bp_if.MispredictE !== 1'b0) begin n_fail++; $display("FAIL beq_second_mis: got %0b want 0", bp_if.MispredictE); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(32'h20, 0, 0, 0, 1, 0, 1, 32'h100, 32'h80);
            tick();
        end
        idle(32'h100);
        n_tests++; if (bp_if.NextPCF !== 32'h80) begin n_fail++; $display("FAIL sat_pred_nextpc: got %h want 80", bp_if.NextPCF); end
        tick();
        idle(32'h20);
        tick();
        drive(32'h20, 0, 1, 1, 1, 0, 0, 32'h100, 32'h80);
        n_tests++; if (bp_if.MispredictE !== 1'b1) begin n_fail++; $display("FAIL sat_nt_mis: got %0b want 1", bp_if.MispredictE); end
        n_tests++; if (bp_if.RedirectPCE !== 32'h104) begin n_fail++; $display("FAIL sat_nt_redirect: got %h want 104", bp_if.RedirectPCE); end
        tick();
        idle(32'h100);
        n_tests++; if (bp_if.PredTakenF !== 1'b1) begin n_fail++; $display("FAIL sat_ctr10_pred: got %0b want 1", bp_if.PredTakenF); end
        tick();
        drive(32'h20, 0, 0, 0, 1, 0, 0, 32'h100, 32'h80);
        tick();
        idle(32'h100);
        n_tests++; if (bp_if.PredTakenF !== 1'b0) begin n_fail++; $display("FAIL sat_ctr01_pred: got %0b want 0", bp_if.PredTakenF); end
        n_tests++; if (bp_if.NextPCF !== 32'h104) begin n_fail++; $display("FAIL sat_ctr01_nextpc: got %h want 104", bp_if.NextPCF); end
        tick();
    endtask

    task automatic test_jalr_target();
        do_reset();
        drive(32'h20, 0, 0, 0, 0, 1, 1, 32'h200, 32'h300);
        tick();
        idle(32'h200);
        n_tests++; if (bp_if.NextPCF !== 32'h300) begin n_fail++; $display("FAIL jalr_pred_nextpc: got %h want 300", bp_if.NextPCF); end
        tick();
        idle(32'h300);
        tick();
        drive(32'h304, 0, 1, 1, 0, 1, 1, 32'h200, 32'h340);
        n_tests++; if (bp_if.MispredictE !== 1'b1) begin n_fail++; $display("FAIL jalr_target_mis: got %0b want 1", bp_if.MispredictE); end
        n_tests++; if (bp_if.RedirectPCE !== 32'h340) begin n_fail++; $display("FAIL jalr_redirect: got %h want 340", bp_if.RedirectPCE); end
        tick();
        idle(32'h200);
        n_tests++; if (bp_if.NextPCF !== 32'h340) begin n_fail++; $display("FAIL jalr_new_target: got %h want 340", bp_if.NextPCF); end
        tick();
    endtask

    task automatic test_alias();
        do_reset();
        drive(32'h20, 0, 0, 0, 1, 0, 1, 32'h100, 32'h80);
        tick();
        idle(32'h140);
`ifdef BP_TAG_EN
        n_tests++; if (bp_if.PredTakenF !== 1'b0) begin n_fail++; $display("FAIL alias_tag_pred: got %0b want 0", bp_if.PredTakenF); end
        n_tests++; if (bp_if.NextPCF !== 32'h144) begin n_fail++; $display("FAIL alias_tag_nextpc: got %h want 144", bp_if.NextPCF); end
        tick();
        idle(32'h100);
        n_tests++; if (bp_if.PredTakenF !== 1'b1) begin n_fail++; $display("FAIL alias_owner_pred: got %0b want 1", bp_if.PredTakenF); end
        tick();
`else
        n_tests++; if (bp_if.PredTakenF !== 1'b1) begin n_fail++; $display("FAIL alias_shared_pred: got %0b want 1", bp_if.PredTakenF); end
        tick();
        idle(32'h144);
        tick();
        drive(32'h148, 0, 1, 1, 0, 0, 0, 32'h140, 32'h0);
        n_tests++; if (bp_if.MispredictE !== 1'b1) begin n_fail++; $display("FAIL alias_mis: got %0b want 1", bp_if.MispredictE); end
        n_tests++; if (bp_if.RedirectPCE !== 32'h144) begin n_fail++; $display("FAIL alias_redirect: got %h want 144", bp_if.RedirectPCE); end
        tick();
        idle(32'h100);
        n_tests++; if (bp_if.PredTakenF !== 1'b0) begin n_fail++; $display("FAIL alias_invalidated: got %0b want 0", bp_if.PredTakenF); end
        tick();
`endif
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(32'h20, 0, 0, 0, 1, 0, 1, 32'h100, 32'h80);
        tick();
        idle(32'h100);
        tick();
        drive(32'h20, 1, 0, 0, 0, 0, 0, 32'h3C, 32'h0);
        tick();
        drive(32'h20, 1, 1, 0, 0, 0, 0, 32'h3C, 32'h0);
        n_tests++; if (bp_if.MispredictE !== 1'b1) begin n_fail++; $display("FAIL stall_load_mis: got %0b want 1", bp_if.MispredictE); end
        tick();
        idle(32'h20);
        n_tests++; if (bp_if.MispredictE !== 1'b1) begin n_fail++; $display("FAIL stall_hold_mis: got %0b want 1", bp_if.MispredictE); end
        tick();
        idle(32'h20);
        n_tests++; if (bp_if.MispredictE !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall_mis: got %0b want 0", bp_if.MispredictE); end
        tick();
        // FlushE drops a taken prediction on its way into Execute
        idle(32'h100);
        tick();
        drive(32'h20, 0, 0, 1, 0, 0, 0, 32'h3C, 32'h0);
        tick();
        idle(32'h20);
        n_tests++; if (bp_if.MispredictE !== 1'b0) begin n_fail++; $display("FAIL flushe_mis: got %0b want 0", bp_if.MispredictE); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(32'h20, 0, 0, 0, 1, 0, 1, 32'h100, 32'h80);
        tick();
        idle(32'h100);
        n_tests++; if (bp_if.PredTakenF !== 1'b1) begin n_fail++; $display("FAIL midrst_before_pred: got %0b want 1", bp_if.PredTakenF); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bp_if.PredTakenF !== 1'b0) begin n_fail++; $display("FAIL midrst_async_pred: got %0b want 0", bp_if.PredTakenF); end
        n_tests++; if (bp_if.NextPCF !== 32'h104) begin n_fail++; $display("FAIL midrst_async_nextpc: got %h want 104", bp_if.NextPCF); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < ENTRIES; i++) begin
            idle(32'h100 + 32'(i * 4));
            n_tests++; if (bp_if.PredTakenF !== 1'b0) begin n_fail++; $display("FAIL midrst_entry%0d_pred: got %0b want 0", i, bp_if.PredTakenF); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] pc_pool  [6];
        logic [31:0] tgt_pool [4];
        logic [31:0] pcf, pce;
        int          kind;
        bit          br, jmp, src;
        bit          exp_pt, exp_mis;
        logic [31:0] exp_np, exp_rd;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            pc_pool[0] = 32'h100; pc_pool[1] = 32'h140; pc_pool[2] = 32'h200;
            pc_pool[3] = 32'h240; pc_pool[4] = 32'h104;
            pc_pool[5] = 32'($urandom_range(0, 1023)) << 2;
            tgt_pool[0] = 32'h80; tgt_pool[1] = 32'h300; tgt_pool[2] = 32'h340;
            tgt_pool[3] = 32'($urandom_range(0, 1023)) << 2;
            pcf  = pc_pool[$urandom_range(0, 5)];
            pce  = pc_pool[$urandom_range(0, 5)];
            kind = $urandom_range(0, 3);
            br   = (kind == 1) || (kind == 2);
            jmp  = (kind == 3);
            src  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            drive(pcf, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), br, jmp, src, pce, tgt_pool[$urandom_range(0, 3)]);
            exp_pt  = m_pred(pcf);
            exp_np  = m_next(pcf);
            exp_mis = m_mis();
            exp_rd  = m_redir();
            n_tests++;
            if ({bp_if.PredTakenF, bp_if.NextPCF, bp_if.MispredictE, bp_if.RedirectPCE} !==
                {exp_pt, exp_np, exp_mis, exp_rd}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got pt=%0b np=%h mis=%0b rd=%h want pt=%0b np=%h mis=%0b rd=%h",
                         c, bp_if.PredTakenF, bp_if.NextPCF, bp_if.MispredictE, bp_if.RedirectPCE,
                         exp_pt, exp_np, exp_mis, exp_rd);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle(32'h20);
        test_reset();
        test_taken_branch();
        test_saturation();
        test_jalr_target();
        test_alias();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
